// File: rtl/dsa_uart_proto_pkg.sv
// ---------------------------------------------------------------------------
// dsa_uart_proto_pkg
// Shared definitions for the DSA UART command protocol: op codes, frame
// opcode bytes, default ACK/NAK bytes, response status encoding, the host
// sequencer state type and the packed latched-request record. Used by both the
// host-side sequencer and the device-side command interface so that both ends
// agree on framing.
// ---------------------------------------------------------------------------
package dsa_uart_proto_pkg;

  typedef enum logic [2:0] {
    OP_WR_MEM = 3'd0,
    OP_RD_MEM = 3'd1,
    OP_START  = 3'd2,
    OP_STATUS = 3'd3,
    OP_CFG    = 3'd4
  } op_e;

  localparam logic [7:0] OPC_WR_MEM = 8'h10;
  localparam logic [7:0] OPC_RD_MEM = 8'h11;
  localparam logic [7:0] OPC_START  = 8'h20;
  localparam logic [7:0] OPC_STATUS = 8'h30;
  localparam logic [7:0] OPC_CFG    = 8'h40;

  localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF = 8'h15;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_NAK     = 2'd1,
    RSP_TIMEOUT = 2'd2,
    RSP_BAD_OP  = 2'd3
  } rsp_status_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } seq_state_e;

  // op is kept as raw bits so illegal codes 5-7 can be carried and rejected.
  typedef struct packed {
    logic [2:0]  op;
    logic [17:0] addr;
    logic [7:0]  data;
    logic [9:0]  width;
    logic [9:0]  height;
    logic [7:0]  scale;
    logic        mode_simd;
  } req_fields_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

  // WR_MEM, START and CFG are answered with ACK/NAK; RD_MEM and STATUS with data.
  function automatic logic op_expects_ack(input logic [2:0] op);
    return (op == OP_WR_MEM) || (op == OP_START) || (op == OP_CFG);
  endfunction

  function automatic logic [2:0] frame_len(input logic [2:0] op);
    case (op)
      OP_WR_MEM: return 3'd5;
      OP_RD_MEM: return 3'd4;
      OP_START:  return 3'd1;
      OP_STATUS: return 3'd1;
      OP_CFG:    return 3'd7;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dsa_uart_frame_builder.sv
// ---------------------------------------------------------------------------
// dsa_uart_frame_builder
// Purely combinational frame byte selector. Given the latched request fields
// and a byte index it returns the frame byte at that position, plus the total
// frame length for the op.
// Ports:
//   fields      in  latched request record
//   idx         in  byte index within the frame (0-based)
//   frame_byte  out byte to transmit at idx (0 outside the frame)
//   frame_len_o out number of bytes in the frame (0 for illegal ops)
// ---------------------------------------------------------------------------
module dsa_uart_frame_builder
  import dsa_uart_proto_pkg::*;
(
  input  req_fields_t fields,
  input  logic [2:0]  idx,
  output logic [7:0]  frame_byte,
  output logic [2:0]  frame_len_o
);

  always_comb begin
    frame_byte  = 8'h00;
    frame_len_o = frame_len(fields.op);
    case (fields.op)
      OP_WR_MEM, OP_RD_MEM: begin
        case (idx)
          3'd0:    frame_byte = (fields.op == OP_WR_MEM) ? OPC_WR_MEM : OPC_RD_MEM;
          3'd1:    frame_byte = {6'b0, fields.addr[17:16]};
          3'd2:    frame_byte = fields.addr[15:8];
          3'd3:    frame_byte = fields.addr[7:0];
          3'd4:    frame_byte = (fields.op == OP_WR_MEM) ? fields.data : 8'h00;
          default: frame_byte = 8'h00;
        endcase
      end
      OP_START:  frame_byte = (idx == 3'd0) ? OPC_START : 8'h00;
      OP_STATUS: frame_byte = (idx == 3'd0) ? OPC_STATUS : 8'h00;
      OP_CFG: begin
        case (idx)
          3'd0:    frame_byte = OPC_CFG;
          3'd1:    frame_byte = {6'b0, fields.width[9:8]};
          3'd2:    frame_byte = fields.width[7:0];
          3'd3:    frame_byte = {6'b0, fields.height[9:8]};
          3'd4:    frame_byte = fields.height[7:0];
          3'd5:    frame_byte = fields.scale;
          3'd6:    frame_byte = {7'b0, fields.mode_simd};
          default: frame_byte = 8'h00;
        endcase
      end
      default: frame_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/dsa_uart_host_sequencer.sv
// ---------------------------------------------------------------------------
// dsa_uart_host_sequencer
// Host-side initiator for the DSA UART command protocol. Accepts one command
// at a time, serialises it onto a byte-stream TX port, waits for the single
// reply byte on the RX port (with timeout) and reports data and status.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a request; req_ready=1
// SEND     | frame bytes presented on tx_data/tx_valid, idx advances on handshake
// WAIT_RSP | waiting for the reply byte; timeout counter running
// DONE     | one-cycle rsp_valid pulse carrying rsp_data/rsp_status
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_*                       request handshake and command fields
//   tx_data/tx_valid/tx_ready   frame byte stream to the PHY
//   rx_data/rx_valid            reply byte strobe from the PHY
//   rsp_valid/rsp_data/rsp_status  completion pulse and result
//   busy                        sequencer not idle
//   drop_count                  saturating count of unsolicited RX bytes
// ---------------------------------------------------------------------------
module dsa_uart_host_sequencer
  import dsa_uart_proto_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE       = NAK_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [17:0] req_addr,
  input  logic [7:0]  req_data,
  input  logic [9:0]  req_width,
  input  logic [9:0]  req_height,
  input  logic [7:0]  req_scale,
  input  logic        req_mode_simd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [1:0]  rsp_status,
  output logic        busy,
  output logic [7:0]  drop_count
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  seq_state_e        state_q, state_d;
  req_fields_t       fields_q, fields_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        len_q, len_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              req_ready_q, req_ready_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  rsp_status_e       rsp_status_q, rsp_status_d;
  logic              busy_q, busy_d;
  logic [7:0]        drop_q, drop_d;

  logic              accept;
  logic              fire;
  logic              last_byte;
  logic [7:0]        fb_byte;
  logic [2:0]        fb_len;

  // Next request fields and byte index are resolved first so the frame builder
  // can look ahead and tx_data can be registered without a combinational loop.
  always_comb begin
    accept    = (state_q == ST_IDLE) && req_valid;
    fire      = (state_q == ST_SEND) && tx_ready;
    last_byte = (idx_q == (len_q - 3'd1));

    fields_d = fields_q;
    if (accept) begin
      fields_d.op        = req_op;
      fields_d.addr      = req_addr;
      fields_d.data      = req_data;
      fields_d.width     = req_width;
      fields_d.height    = req_height;
      fields_d.scale     = req_scale;
      fields_d.mode_simd = req_mode_simd;
    end

    idx_d = idx_q;
    if (accept) begin
      idx_d = 3'd0;
    end else if (fire && !last_byte) begin
      idx_d = idx_q + 3'd1;
    end
  end

  dsa_uart_frame_builder u_frame_builder (
    .fields      (fields_d),
    .idx         (idx_d),
    .frame_byte  (fb_byte),
    .frame_len_o (fb_len)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    tmo_d        = tmo_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    drop_d       = drop_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_is_legal(req_op)) begin
            state_d = ST_SEND;
            len_d   = fb_len;
          end else begin
            state_d      = ST_DONE;
            rsp_status_d = RSP_BAD_OP;
            rsp_data_d   = 8'h00;
          end
        end
      end
      ST_SEND: begin
        if (fire && last_byte) begin
          state_d = ST_WAIT_RSP;
          tmo_d   = '0;
        end
      end
      ST_WAIT_RSP: begin
        // A byte arriving on the final timeout cycle still counts as the reply.
        if (rx_valid) begin
          state_d    = ST_DONE;
          rsp_data_d = rx_data;
          if (op_expects_ack(fields_q.op)) begin
            rsp_status_d = (rx_data == ACK_BYTE) ? RSP_OK : RSP_NAK;
          end else begin
            rsp_status_d = (rx_data == NAK_BYTE) ? RSP_NAK : RSP_OK;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d      = ST_DONE;
          rsp_status_d = RSP_TIMEOUT;
          rsp_data_d   = 8'h00;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (rx_valid && (state_q != ST_WAIT_RSP) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    req_ready_d = (state_d == ST_IDLE);
    tx_valid_d  = (state_d == ST_SEND);
    tx_data_d   = (state_d == ST_SEND) ? fb_byte : 8'h00;
    rsp_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fields_q     <= '0;
      idx_q        <= 3'd0;
      len_q        <= 3'd0;
      tmo_q        <= '0;
      req_ready_q  <= 1'b1;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 8'h00;
      rsp_status_q <= RSP_OK;
      busy_q       <= 1'b0;
      drop_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      fields_q     <= fields_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      tmo_q        <= tmo_d;
      req_ready_q  <= req_ready_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign busy       = busy_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_dsa_uart_host_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dsa_uart_host_sequencer
// Directed self-checking bench for dsa_uart_host_sequencer with a short
// timeout (16 cycles). Inputs are driven and outputs sampled 1 ns after each
// rising edge.
// ---------------------------------------------------------------------------
module tb_dsa_uart_host_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [17:0] req_addr = '0;
  logic [7:0]  req_data = '0;
  logic [9:0]  req_width = '0;
  logic [9:0]  req_height = '0;
  logic [7:0]  req_scale = '0;
  logic        req_mode_simd = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [7:0]  drop_count;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] exp_b [8];

  dsa_uart_host_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_width     (req_width),
    .req_height    (req_height),
    .req_scale     (req_scale),
    .req_mode_simd (req_mode_simd),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_status    (rsp_status),
    .busy          (busy),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Presents a request for one cycle, then scrambles every input field so a
  // frame built from live inputs instead of latched ones is caught.
  task automatic issue(input logic [2:0] op, input logic [17:0] addr, input logic [7:0] data,
                       input logic [9:0] w, input logic [9:0] h, input logic [7:0] scale,
                       input logic mode);
    req_op = op; req_addr = addr; req_data = data;
    req_width = w; req_height = h; req_scale = scale; req_mode_simd = mode;
    req_valid = 1'b1;
    chk("req_ready_idle", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    req_op = 3'd7; req_addr = ~addr; req_data = ~data;
    req_width = ~w; req_height = ~h; req_scale = ~scale; req_mode_simd = ~mode;
  endtask

  // Consumes n frame bytes, checking each presented byte against exp_b; with
  // throttle, tx_ready alternates 0/1 starting at 0 so every byte sees a stall.
  task automatic run_tx(input int n, input bit throttle);
    int k = 0;
    int cyc = 0;
    bit rdy = 1'b0;
    while (k < n && cyc < 100) begin
      tx_ready = throttle ? rdy : 1'b1;
      if (tx_valid) begin
        chk($sformatf("tx_byte%0d", k), 32'(tx_data), 32'(exp_b[k]));
        if (tx_ready) k++;
      end
      tick();
      rdy = ~rdy;
      cyc++;
    end
    tx_ready = 1'b1;
    chk("tx_byte_count", 32'(k), 32'(n));
    chk("tx_valid_after_frame", 32'(tx_valid), 0);
  endtask

  task automatic reply(input logic [7:0] b, input logic [1:0] st);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("rsp_valid_pulse", 32'(rsp_valid), 1);
    chk("rsp_status", 32'(rsp_status), 32'(st));
    chk("rsp_data", 32'(rsp_data), 32'(b));
    tick();
    chk("rsp_valid_one_cycle", 32'(rsp_valid), 0);
    chk("req_ready_back", 32'(req_ready), 1);
    chk("busy_clear", 32'(busy), 0);
  endtask

  initial begin
    bit early;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_status", 32'(rsp_status), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    tick();

    // WR_MEM 0x2ABCD <- 0x5A, reply ACK
    issue(3'd0, 18'h2ABCD, 8'h5A, 10'd0, 10'd0, 8'h00, 1'b0);
    chk("wr_first_tx_latency", 32'(tx_valid), 1);
    chk("wr_busy", 32'(busy), 1);
    exp_b = '{8'h10, 8'h02, 8'hAB, 8'hCD, 8'h5A, 8'h00, 8'h00, 8'h00};
    run_tx(5, 1'b0);
    reply(8'h06, 2'd0);

    // RD_MEM 0x00010, throttled TX, reply 0x7F
    issue(3'd1, 18'h00010, 8'h00, 10'd0, 10'd0, 8'h00, 1'b0);
    exp_b = '{8'h11, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    run_tx(4, 1'b1);
    reply(8'h7F, 2'd0);

    // CFG w=512 h=300 scale=0x80 simd=1, reply NAK
    issue(3'd4, 18'h0, 8'h00, 10'd512, 10'd300, 8'h80, 1'b1);
    exp_b = '{8'h40, 8'h02, 8'h00, 8'h01, 8'h2C, 8'h80, 8'h01, 8'h00};
    run_tx(7, 1'b0);
    reply(8'h15, 2'd1);

    // START answered with a byte that is neither ACK nor NAK
    issue(3'd2, 18'h0, 8'h00, 10'd0, 10'd0, 8'h00, 1'b0);
    exp_b = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_tx(1, 1'b0);
    reply(8'h55, 2'd1);

    // STATUS with no reply: handshake edge is the last tick of run_tx, the
    // timeout completion becomes visible after the 16th edge following it.
    issue(3'd3, 18'h0, 8'h00, 10'd0, 10'd0, 8'h00, 1'b0);
    exp_b = '{8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_tx(1, 1'b0);
    early = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rsp_valid) early = 1'b1;
    end
    chk("timeout_not_early", 32'(early), 0);
    tick();
    chk("timeout_rsp_valid", 32'(rsp_valid), 1);
    chk("timeout_status", 32'(rsp_status), 2);
    chk("timeout_data", 32'(rsp_data), 0);
    tick();
    chk("timeout_idle", 32'(req_ready), 1);
    rx_data = 8'hAA;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("late_byte_dropped", 32'(drop_count), 1);
    chk("late_byte_no_rsp", 32'(rsp_valid), 0);

    // Illegal op 6: completion pulse in the cycle after the accept cycle
    issue(3'd6, 18'h0, 8'h00, 10'd0, 10'd0, 8'h00, 1'b0);
    chk("badop_rsp_valid", 32'(rsp_valid), 1);
    chk("badop_status", 32'(rsp_status), 3);
    chk("badop_data", 32'(rsp_data), 0);
    chk("badop_no_tx", 32'(tx_valid), 0);
    tick();
    chk("badop_pulse_end", 32'(rsp_valid), 0);
    chk("badop_no_tx2", 32'(tx_valid), 0);
    chk("badop_ready", 32'(req_ready), 1);

    // drop_count saturation
    rx_data = 8'h33;
    rx_valid = 1'b1;
    repeat (300) tick();
    rx_valid = 1'b0;
    chk("drop_saturate", 32'(drop_count), 255);

    // Reset in the middle of a CFG frame
    issue(3'd4, 18'h0, 8'h00, 10'd512, 10'd300, 8'h80, 1'b1);
    tick();
    tick();
    chk("midcfg_sending", 32'(tx_valid), 1);
    chk("midcfg_byte2", 32'(tx_data), 'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_tx_valid", 32'(tx_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_drop_clear", 32'(drop_count), 0);
    early = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid || tx_valid) early = 1'b1;
    end
    chk("midrst_quiet", 32'(early), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
